// File: rtl/w_dispatch.sv
// W-channel dispatcher: steers master write beats to the slave addressed by the
// AW FIFO head, generates the burst's last flag and logs completed bursts for B ordering.
module w_dispatch #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    localparam int SEL_W     = $clog2(NUM_SLAVES),
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  aw_empty,
    input  logic [ID_WIDTH-1:0]   aw_front_id,
    input  logic [ADDR_WIDTH-1:0] aw_front_addr,
    input  logic [LEN_WIDTH-1:0]  aw_front_len,
    output logic                  aw_pop,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [STRB_W-1:0]     WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [DATA_WIDTH-1:0] S_WDATA,
    output logic [STRB_W-1:0]     S_WSTRB,
    output logic                  S_WLAST,
    output logic [NUM_SLAVES-1:0] S_WVALID,
    input  logic [NUM_SLAVES-1:0] S_WREADY,
    input  logic                  b_full,
    output logic                  b_push,
    output logic [ID_WIDTH-1:0]   b_id,
    output logic [SEL_W-1:0]      b_sel,
    output logic                  wlast_err
);

    typedef enum logic {
        IDLE,
        DATA
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q;
    logic [ID_WIDTH-1:0]    id_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   cnt_q;
    logic                   err_q;
    logic                   last;
    logic                   stall;
    logic                   hs;
    logic                   unused_addr;

    // Only the top address bits select the slave.
    assign unused_addr = ^aw_front_addr[ADDR_WIDTH-SEL_W-1:0];

    assign last  = (cnt_q == len_q);
    // The final beat is held back while its completion record has nowhere to go.
    assign stall = last & b_full;

    assign S_WDATA   = WDATA;
    assign S_WSTRB   = WSTRB;
    assign b_id      = ARESETn ? id_q  : '0;
    assign b_sel     = ARESETn ? sel_q : '0;
    assign wlast_err = err_q;

    always_comb begin
        state_d  = state_q;
        S_WVALID = '0;
        WREADY   = 1'b0;
        S_WLAST  = 1'b0;
        hs       = 1'b0;
        aw_pop   = 1'b0;
        b_push   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!aw_empty) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                S_WVALID[sel_q] = WVALID & ~stall;
                WREADY          = S_WREADY[sel_q] & ~stall;
                S_WLAST         = last;
                hs              = WVALID & WREADY;
                if (hs && last) begin
                    aw_pop  = ~aw_empty;
                    b_push  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs stay quiet for the whole time reset is held, not only after its edge.
        if (!ARESETn) begin
            state_d  = IDLE;
            S_WVALID = '0;
            WREADY   = 1'b0;
            S_WLAST  = 1'b0;
            hs       = 1'b0;
            aw_pop   = 1'b0;
            b_push   = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            sel_q   <= '0;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && !aw_empty) begin
                sel_q <= aw_front_addr[ADDR_WIDTH-1 -: SEL_W];
                id_q  <= aw_front_id;
                len_q <= aw_front_len;
                cnt_q <= '0;
            end
            if (hs) begin
                if (!last) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (WLAST != last) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_w_dispatch.sv
// Scoreboard bench for w_dispatch: an AW queue model, a randomized W master,
// and a monitor checking slave-side beats and completion records against expectations.
module tb_w_dispatch;

    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int LW  = 4;
    localparam int DW  = 32;
    localparam int NS  = 4;
    localparam int SW  = 2;
    localparam int STW = DW / 8;

    typedef struct {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        int             len;
        int             sel;
        int             bad;
    } burst_t;

    typedef struct {
        int             sel;
        logic [DW-1:0]  data;
        logic [STW-1:0] strb;
        bit             last;
    } beat_t;

    typedef struct {
        logic [IDW-1:0] id;
        int             sel;
    } brec_t;

    logic           ACLK = 1'b0;
    logic           ARESETn = 1'b0;
    logic           aw_empty = 1'b1;
    logic [IDW-1:0] aw_front_id = '0;
    logic [AW-1:0]  aw_front_addr = '0;
    logic [LW-1:0]  aw_front_len = '0;
    logic           aw_pop;
    logic [DW-1:0]  WDATA = '0;
    logic [STW-1:0] WSTRB = '0;
    logic           WLAST = 1'b0;
    logic           WVALID = 1'b0;
    logic           WREADY;
    logic [DW-1:0]  S_WDATA;
    logic [STW-1:0] S_WSTRB;
    logic           S_WLAST;
    logic [NS-1:0]  S_WVALID;
    logic [NS-1:0]  S_WREADY = '0;
    logic           b_full = 1'b0;
    logic           b_push;
    logic [IDW-1:0] b_id;
    logic [SW-1:0]  b_sel;
    logic           wlast_err;

    w_dispatch #(
        .ID_WIDTH   (IDW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .DATA_WIDTH (DW),
        .NUM_SLAVES (NS)
    ) dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .aw_empty      (aw_empty),
        .aw_front_id   (aw_front_id),
        .aw_front_addr (aw_front_addr),
        .aw_front_len  (aw_front_len),
        .aw_pop        (aw_pop),
        .WDATA         (WDATA),
        .WSTRB         (WSTRB),
        .WLAST         (WLAST),
        .WVALID        (WVALID),
        .WREADY        (WREADY),
        .S_WDATA       (S_WDATA),
        .S_WSTRB       (S_WSTRB),
        .S_WLAST       (S_WLAST),
        .S_WVALID      (S_WVALID),
        .S_WREADY      (S_WREADY),
        .b_full        (b_full),
        .b_push        (b_push),
        .b_id          (b_id),
        .b_sel         (b_sel),
        .wlast_err     (wlast_err)
    );

    always #5 ACLK = ~ACLK;

    burst_t add_q[$], aw_q[$], w_plan[$];
    beat_t  exp_w[$];
    brec_t  exp_b[$];

    int n_cmp = 0;
    int n_mis = 0;
    int xfer_cnt = 0;
    int stall_cnt = 0;

    // Environment knobs: 0 random, 1 forced value, 2 toggle every cycle.
    int            rdy_mode = 1;
    logic [NS-1:0] rdy_force = '1;
    int            bf_mode = 1;
    logic          bf_force = 1'b0;
    int            vprob = 100;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic enqueue(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                           input int len, input int bad);
        burst_t b;
        brec_t  r;
        b.id   = id;
        b.addr = addr;
        b.len  = len;
        b.sel  = int'(addr >> (AW - SW));
        b.bad  = bad;
        r.id   = id;
        r.sel  = b.sel;
        add_q.push_back(b);
        w_plan.push_back(b);
        exp_b.push_back(r);
    endtask

    task automatic wait_drain(input int max_cycles);
        bit done = 0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge ACLK);
            done = (add_q.size() == 0) && (aw_q.size() == 0) && (w_plan.size() == 0) &&
                   (exp_w.size() == 0) && (exp_b.size() == 0);
        end
        chk("drain_timeout", done, 1);
    endtask

    // AW FIFO model and slave/B-FIFO behaviour.
    bit pop_seen = 0;
    always @(negedge ACLK) pop_seen = aw_pop;

    always @(posedge ACLK) begin
        #1;
        if (pop_seen && aw_q.size() > 0) void'(aw_q.pop_front());
        while (add_q.size() > 0) aw_q.push_back(add_q.pop_front());
        aw_empty = (aw_q.size() == 0);
        if (aw_q.size() > 0) begin
            aw_front_id   = aw_q[0].id;
            aw_front_addr = aw_q[0].addr;
            aw_front_len  = LW'(aw_q[0].len);
        end else begin
            aw_front_id   = IDW'($urandom);
            aw_front_addr = $urandom;
            aw_front_len  = LW'($urandom);
        end
        case (rdy_mode)
            0:       S_WREADY = NS'($urandom);
            2:       S_WREADY = ~S_WREADY;
            default: S_WREADY = rdy_force;
        endcase
        b_full = (bf_mode == 0) ? ($urandom_range(0, 4) == 0) : bf_force;
    end

    // W master: presents the planned bursts beat by beat, holding each until accepted.
    bit m_acc = 0;
    bit m_abort = 0;
    bit m_rst = 1;
    bit presenting = 0;
    int cur_beat = 0;

    always @(negedge ACLK) begin
        m_acc = WVALID && WREADY;
        if (!ARESETn) m_abort = 1;
        m_rst = !ARESETn;
    end

    always @(posedge ACLK) begin
        burst_t p;
        beat_t  e;
        #1;
        if (m_abort) begin
            m_abort    = 0;
            presenting = 0;
            cur_beat   = 0;
            WVALID     = 1'b0;
            exp_w.delete();
        end else if (presenting && m_acc) begin
            presenting = 0;
            WVALID     = 1'b0;
            if (cur_beat == w_plan[0].len) begin
                void'(w_plan.pop_front());
                cur_beat = 0;
            end else begin
                cur_beat++;
            end
        end
        if (!presenting && !m_rst && w_plan.size() > 0 && $urandom_range(0, 99) < vprob) begin
            p      = w_plan[0];
            WDATA  = $urandom;
            WSTRB  = STW'($urandom);
            WLAST  = (cur_beat == p.len) ^ (cur_beat == p.bad);
            WVALID = 1'b1;
            e.sel  = p.sel;
            e.data = WDATA;
            e.strb = WSTRB;
            e.last = (cur_beat == p.len);
            exp_w.push_back(e);
            presenting = 1;
        end
    end

    // Monitor: sampled mid-cycle, each observation describes the transfer at the next rising edge.
    bit err_m = 0;
    bit gap_next = 0;

    always @(negedge ACLK) begin
        beat_t e;
        brec_t r;
        int    idx;
        bit    s_fire;
        bit    m_hs;
        bit    err_pend;
        err_pend = 0;
        if (!ARESETn) begin
            chk("reset_outputs", {aw_pop, b_push, WREADY, S_WVALID, S_WLAST, b_id, b_sel}, 0);
            err_m    = 0;
            gap_next = 0;
        end else begin
            chk("wlast_err", wlast_err, err_m);
            s_fire = |(S_WVALID & S_WREADY);
            m_hs   = WVALID && WREADY;
            if (S_WVALID != 0) chk("s_wvalid_onehot", $countones(S_WVALID), 1);
            if (m_hs || s_fire) chk("hs_agree", m_hs, s_fire);
            if (gap_next) chk("idle_gap", {S_WVALID, WREADY, aw_pop}, 0);
            gap_next = 0;
            if (WVALID && b_full && exp_w.size() > 0 && exp_w[0].last) begin
                chk("final_beat_stall", {S_WVALID, WREADY}, 0);
                stall_cnt++;
            end
            if (s_fire) begin
                chk("beat_pending", exp_w.size() > 0, 1);
                if (exp_w.size() > 0) begin
                    e   = exp_w.pop_front();
                    idx = -1;
                    for (int k = 0; k < NS; k++)
                        if (S_WVALID[k] && S_WREADY[k]) idx = k;
                    chk("beat_slave", idx, e.sel);
                    chk("beat_data", S_WDATA, e.data);
                    chk("beat_strb", S_WSTRB, e.strb);
                    chk("beat_last", S_WLAST, e.last);
                    if (WLAST != e.last) err_pend = 1;
                end
                xfer_cnt++;
            end
            if (aw_pop || b_push) chk("pop_push_pair", aw_pop, b_push);
            if (aw_pop) chk("pop_nonempty", aw_empty, 0);
            if (b_push) begin
                chk("b_pending", exp_b.size() > 0, 1);
                if (exp_b.size() > 0) begin
                    r = exp_b.pop_front();
                    chk("b_id", b_id, r.id);
                    chk("b_sel", b_sel, r.sel);
                end
                gap_next = 1;
            end
            if (err_pend) err_m = 1;
        end
    end

    initial begin
        int base;
        int len;
        int sel;
        logic [AW-1:0] addr;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("reset_wlast_err", wlast_err, 0);
        @(posedge ACLK);
        #1 ARESETn = 1'b1;

        // Single beat to slave 1.
        enqueue(4'd3, 32'h4000_0000, 0, -1);
        wait_drain(50);

        // Four beats to slave 3 with ready toggling.
        rdy_mode = 2;
        enqueue(4'd5, 32'hC000_0010, 3, -1);
        wait_drain(80);

        // Completion FIFO full at the final beat.
        rdy_mode = 1;
        bf_force = 1'b1;
        base = stall_cnt;
        enqueue(4'd6, 32'h8000_0000, 1, -1);
        repeat (8) @(posedge ACLK);
        #1 bf_force = 1'b0;
        wait_drain(50);
        chk("stall_observed", stall_cnt > base, 1);

        // Back-to-back queued entries.
        enqueue(4'd1, 32'h0000_0100, 0, -1);
        enqueue(4'd2, 32'h8000_0000, 1, -1);
        wait_drain(50);

        // Randomized traffic.
        rdy_mode = 0;
        bf_mode  = 0;
        vprob    = 70;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 500 && (add_q.size() + aw_q.size()) >= 3; k++) @(posedge ACLK);
            len  = $urandom_range(0, 7);
            sel  = $urandom_range(0, NS - 1);
            addr = ($urandom() & 32'h3FFF_FFFF) | (AW'(sel) << (AW - SW));
            enqueue(IDW'($urandom), addr, len, -1);
            repeat ($urandom_range(0, 4)) @(posedge ACLK);
        end
        wait_drain(3000);
        chk("no_wlast_err_clean", wlast_err, 0);

        // Early master WLAST on beat 1 of a 3-beat burst.
        rdy_mode = 1;
        bf_mode  = 1;
        vprob    = 100;
        enqueue(4'd7, 32'h0000_0000, 2, 1);
        wait_drain(50);
        chk("wlast_err_set", wlast_err, 1);
        enqueue(4'd8, 32'h4000_0000, 1, -1);
        wait_drain(50);
        chk("wlast_err_sticky", wlast_err, 1);

        // Reset after two of four beats; the head entry must be replayed from beat 0.
        base = xfer_cnt;
        enqueue(4'd9, 32'h8000_0040, 3, -1);
        for (int k = 0; k < 60 && (xfer_cnt - base) < 2; k++) @(posedge ACLK);
        chk("two_beats_before_reset", xfer_cnt - base >= 2, 1);
        #1 ARESETn = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("reset_clears_wlast_err", wlast_err, 0);
        chk("reset_no_pop", {aw_pop, b_push}, 0);
        @(posedge ACLK);
        #1 ARESETn = 1'b1;
        base = xfer_cnt;
        wait_drain(60);
        chk("replayed_beats", xfer_cnt - base, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
